// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and defaults for the down_timer block
//
// Contents:
//   state_t            IDLE / RUN / DONE controller states (2-bit)
//   DEFAULT_WIDTH      default count/data width
//   DEFAULT_PRE_WIDTH  default prescaler divisor width
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH     = 16;
  localparam int DEFAULT_PRE_WIDTH = 8;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing one tick every prescale+1 active cycles
//
// Ports:
//   clk       clock, all state changes on posedge
//   rst       asynchronous active-low reset
//   clear     restart the prescale count (timer load); suppresses tick
//   active    counting allowed this cycle (running & en)
//   prescale  divisor minus one, sampled live
//   tick      combinational tick, valid in the cycle the count matches
module tick_gen
  import timer_pkg::*;
#(
  parameter int pre_width = DEFAULT_PRE_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 active,
  input  logic [pre_width-1:0] prescale,
  output logic                 tick
);

  localparam logic [pre_width-1:0] PRE_ONE = {{(pre_width-1){1'b0}}, 1'b1};

  logic [pre_width-1:0] pre_cnt;
  logic                 hit;

  // Equality (not >=) so a divisor lowered below the running count lets
  // the counter run on, wrap through zero and match on the way back up.
  assign hit  = (pre_cnt == prescale);
  assign tick = active & hit & ~clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
    end else if (clear) begin
      pre_cnt <= '0;
    end else if (active) begin
      pre_cnt <= hit ? '0 : pre_cnt + PRE_ONE;
    end
  end

endmodule

// File: rtl/down_timer.sv
// rtl/down_timer.sv - programmable countdown timer with reload, prescaler and sticky irq
//
// Ports:
//   clk       clock, all state changes on posedge
//   rst       asynchronous active-low reset
//   en        count enable; 0 freezes prescaler and value
//   we        load strobe; data -> reload and value
//   data      load value
//   periodic  1 = auto-reload on expiry, 0 = one-shot (sampled at expiry)
//   prescale  tick every prescale+1 enabled cycles
//   irq_ack   clears irq (an expiry in the same cycle wins)
//   value     current count
//   zero      one-cycle registered pulse on expiry
//   irq       sticky interrupt request
//   running   1 while state is RUN
module down_timer
  import timer_pkg::*;
#(
  parameter int width     = DEFAULT_WIDTH,
  parameter int pre_width = DEFAULT_PRE_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 we,
  input  logic [width-1:0]     data,
  input  logic                 periodic,
  input  logic [pre_width-1:0] prescale,
  input  logic                 irq_ack,
  output logic [width-1:0]     value,
  output logic                 zero,
  output logic                 irq,
  output logic                 running
);

  localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_next;
  logic [width-1:0] reload;
  logic             tick;
  logic             expire;

  assign running = (state == RUN);

  tick_gen #(
    .pre_width(pre_width)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (we),
    .active   (running & en),
    .prescale (prescale),
    .tick     (tick)
  );

  // tick is already masked by we, so a load on the expiry cycle wins.
  assign expire = tick & (value == ONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (we) begin
      state_next = (data != '0) ? RUN : IDLE;
    end else if (expire && !periodic) begin
      state_next = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value  <= '0;
      reload <= '0;
      zero   <= 1'b0;
      irq    <= 1'b0;
    end else begin
      zero <= expire;

      if (expire) begin
        irq <= 1'b1;
      end else if (irq_ack) begin
        irq <= 1'b0;
      end

      if (we) begin
        reload <= data;
        value  <= data;
      end else if (expire) begin
        value <= periodic ? reload : '0;
      end else if (tick) begin
        value <= value - ONE;
      end
    end
  end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
Programmable countdown timer with reload, prescaler and interrupt for the RedCPU peripheral set. It decrements a loaded value once per prescaled tick. On expiry it pulses `zero` and raises a sticky `irq`, which the CPU clears with `irq_ack`. In periodic mode it reloads automatically; in one-shot mode it halts at 0.

Parameters:
- width, 16, data/count bus width
- pre_width, 8, prescaler divisor width

Ports:
- clk  input  1  clock; all state changes on posedge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- en  input  1  count enable; 0 freezes prescaler and value
- we  input  1  load strobe; writes `data` into reload and value
- data  input  width  load value
- periodic  input  1  1 = auto-reload on expiry, 0 = one-shot
- prescale  input  pre_width  tick every prescale+1 enabled cycles
- irq_ack  input  1  clears irq
- value  output  width  current count
- zero  output  1  one-cycle pulse on expiry
- irq  output  1  sticky interrupt request
- running  output  1  1 while state = RUN

Behaviour:
- Reset (rst=0, async): value=0, reload=0, pre_cnt=0, zero=0, irq=0, state=IDLE, running=0.
- States:
  - IDLE: no counting.
  - RUN: counting.
  - DONE: one-shot expired; value held at 0.
- Priority within a cycle: we > tick > hold.
- Load (we=1, any state):
  - reload<=data, value<=data, pre_cnt<=0, zero<=0.
  - state<=RUN if data!=0, else IDLE.
  - irq unaffected.
- Prescaler:
  - Active only in RUN with en=1.
  - When pre_cnt==prescale: tick=1 and pre_cnt<=0; otherwise pre_cnt<=pre_cnt+1.
  - prescale=0 gives a tick every enabled cycle.
  - `prescale` is sampled live; if changed below the current pre_cnt, the tick fires when pre_cnt wraps at 2^pre_width-1.
- On tick with value>1: value<=value-1.
- On tick with value==1 (expiry):
  - zero<=1 for exactly one cycle; irq<=1.
  - periodic=1: value<=reload, stay in RUN. Period = reload*(prescale+1) enabled cycles.
  - periodic=0: value<=0, state<=DONE.
- en=0: value and pre_cnt hold; no tick; state unchanged.
- `periodic` is sampled only at expiry; mid-run changes apply at the next expiry.
- irq:
  - Set on expiry; cleared by irq_ack=1.
  - Same-cycle expiry and irq_ack: irq stays 1 (set wins).
- zero is registered, asserted the cycle after the tick edge; it deasserts the following cycle.
- DONE and IDLE leave only via we=1.
- Reset mid-count aborts immediately; all outputs return to reset values asynchronously.
- Arithmetic: unsigned, modulo width. value never underflows because a tick at value==0 cannot occur in RUN.

Decomposition:
- Package `timer_pkg`: state enum {IDLE, RUN, DONE} (2-bit encoding) and DEFAULT_WIDTH/DEFAULT_PRE_WIDTH constants.
- One sub-module, `tick_gen`:
  - Ports: clk, rst, clear (=we), active (=running & en), prescale → tick.
  - Holds pre_cnt.

Test Plan:
- Reset: assert rst=0 mid-run with value=0x0005 → value=0, irq=0, zero=0, running=0 immediately (before the next edge).
- One-shot: periodic=0, prescale=0, load data=3, en=1 → value 3,2,1,0 on successive edges; zero high one cycle; irq=1; running=0; value stays 0 for 10 further cycles.
- Periodic with prescaler: periodic=1, prescale=2, load data=2 → zero pulses every 6 cycles; value reloads to 2; irq stays 1 until irq_ack; irq_ack clears it for one period, then it sets again.
- Enable freeze: load 4, prescale=1, en=0 after 3 cycles for 5 cycles → value and pre_cnt frozen; resuming en=1 completes expiry exactly 5 cycles later than the unfrozen case.
- Simultaneous events:
  - irq_ack on the expiry cycle → irq remains 1.
  - we=1 with data=7 on the expiry cycle → value=7, no zero pulse, state RUN.
- Zero load: load data=0 with en=1 → running=0, value=0, no zero/irq over 20 cycles; subsequent load data=1 → expiry after one tick.
